// File: rtl/key_pkg.sv
// Shared constants and small helpers for the key capture bank and its per-channel debouncer.
package key_pkg;

    localparam logic LED_MODE_FOLLOW     = 1'b0;
    localparam logic LED_MODE_TOGGLE     = 1'b1;

    localparam int DEBOUNCE_20MS_50MHZ   = 1_000_000;
    localparam int SIM_DEBOUNCE_CYC      = 4;

    // Level a released key presents on its pin.
    function automatic logic idle_level(input bit active_low);
        return logic'(active_low);
    endfunction

    // Converts a pin sample into "1 = pressed" polarity.
    function automatic logic normalise(input logic raw, input bit active_low);
        return raw ^ logic'(active_low);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: pin synchroniser, debounce counter, clean level and press/release pulses.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_CYC   = DEBOUNCE_20MS_50MHZ,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic level_next,
    output logic press_next
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic             IDLE     = idle_level(KEY_ACTIVE_LOW);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   sample;
    logic                   differ;
    logic                   accept;
    logic                   release_next;

    assign sample       = normalise(sync_p0[SYNC_STAGES-1], KEY_ACTIVE_LOW);
    assign differ       = (sample != key_level);
    assign accept       = differ && (cnt_p1 == CNT_LAST);
    assign level_next   = key_level ^ accept;
    assign press_next   = accept & ~key_level;
    assign release_next = accept & key_level;

    // Stage p0: metastability chain, held at the idle pin level in reset
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_p0 <= {SYNC_STAGES{IDLE}};
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], key_in};
        end
    end

    // Stage p1: any sample matching the current level restarts the count
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_p1      <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            if (!differ || accept) begin
                cnt_p1 <= '0;
            end else begin
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
            key_level   <= level_next;
            key_press   <= press_next;
            key_release <= release_next;
        end
    end

endmodule

// File: rtl/key_capture_bank.sv
// Multi-channel key capture: per-channel debouncers plus per-channel follow/toggle LED drive.
module key_capture_bank
    import key_pkg::*;
#(
    parameter int CH_NUM         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_CYC   = DEBOUNCE_20MS_50MHZ,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [CH_NUM-1:0] key_in,
    input  logic [CH_NUM-1:0] led_mode,
    output logic [CH_NUM-1:0] key_level,
    output logic [CH_NUM-1:0] key_press,
    output logic [CH_NUM-1:0] key_release,
    output logic [CH_NUM-1:0] led_out
);

    logic [CH_NUM-1:0] level_next;
    logic [CH_NUM-1:0] press_next;

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        key_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYC   (DEBOUNCE_CYC),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .key_in      (key_in[gi]),
            .key_level   (key_level[gi]),
            .key_press   (key_press[gi]),
            .key_release (key_release[gi]),
            .level_next  (level_next[gi]),
            .press_next  (press_next[gi])
        );
    end

    // Follow mode loads the same next value as key_level, so the two never skew
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led_out <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (led_mode[i] == LED_MODE_TOGGLE) begin
                    led_out[i] <= led_out[i] ^ press_next[i];
                end else begin
                    led_out[i] <= level_next[i];
                end
            end
        end
    end

endmodule
